// File: rtl/revive_ahbl_arbiter.sv
// revive_ahbl_arbiter
// Shares one AHB-lite master port between the instruction-fetch requester (I)
// and the load/store requester (D). The address phase is chosen combinationally
// each cycle. The owner of the outstanding data phase is remembered so that
// completion or error goes back to the right requester. Store data is
// registered for the data phase.
//
// Handshake: a requester raises x_req and holds its request fields stable
// until x_gnt is seen high at a clock edge. x_gnt means the address phase was
// accepted on that edge. The matching x_done or x_err pulses for exactly one
// cycle when that data phase finishes (hready high). x_done and x_err are
// never raised together, and the earliest completion is the cycle after the
// grant.
//
// Debug outputs: dbg_owner exposes the data-phase owner register
// (0 = none, 1 = I, 2 = D). dbg_streak exposes the consecutive-D-grant
// counter.
module revive_ahbl_arbiter #(
    parameter int W_ADDR       = 32,
    parameter int W_DATA       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    // instruction fetch requester
    input  logic                                i_req,
    input  logic [W_ADDR-1:0]                   i_addr,
    output logic                                i_gnt,
    output logic                                i_done,
    output logic                                i_err,
    // load/store requester
    input  logic                                d_req,
    input  logic [W_ADDR-1:0]                   d_addr,
    input  logic [2:0]                          d_size,
    input  logic                                d_write,
    input  logic [W_DATA-1:0]                   d_wdata,
    output logic                                d_gnt,
    output logic                                d_done,
    output logic                                d_err,
    output logic [W_DATA-1:0]                   rdata,
    // AHB-lite master port
    input  logic                                hready,
    input  logic                                hresp,
    output logic [W_ADDR-1:0]                   haddr,
    output logic                                hwrite,
    output logic [1:0]                          htrans,
    output logic [2:0]                          hsize,
    output logic [W_DATA-1:0]                   hwdata,
    input  logic [W_DATA-1:0]                   hrdata,
    // debug visibility of internal state
    output logic [1:0]                          dbg_owner,
    output logic [$clog2(MAX_D_STREAK+1)-1:0]   dbg_streak
);

    localparam int                  W_STREAK   = $clog2(MAX_D_STREAK + 1);
    localparam logic [W_STREAK-1:0] STREAK_MAX = W_STREAK'(MAX_D_STREAK);
    localparam logic [1:0]          HTRANS_IDLE = 2'b00;
    localparam logic [1:0]          HTRANS_NSEQ = 2'b10;
    localparam logic [2:0]          HSIZE_WORD  = 3'd2;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    owner_e              owner_q, owner_d;
    logic                wr_q;
    logic [W_DATA-1:0]   wdata_q;
    logic [W_STREAK-1:0] streak_q, streak_d;

    logic err1;      // first cycle of a two-cycle ERROR response
    logic i_force;   // D has had its run of grants; fetch must go next
    logic sel_i;
    logic sel_d;
    logic cmpl;      // outstanding data phase finishes this cycle

    // Pick the requester that drives the address phase this cycle.
    always_comb begin
        err1    = hresp && !hready;
        i_force = i_req && (streak_q == STREAK_MAX);
        sel_d   = !rst && d_req && !i_force;
        sel_i   = !rst && i_req && !sel_d;
    end

    // Drive the AHB address phase from the selected requester. During the
    // first ERROR cycle the transfer is suppressed (IDLE) and nothing is granted.
    always_comb begin
        haddr  = '0;
        hsize  = '0;
        hwrite = 1'b0;
        htrans = HTRANS_IDLE;
        if (sel_d) begin
            haddr  = d_addr;
            hsize  = d_size;
            hwrite = d_write;
        end else if (sel_i) begin
            haddr  = i_addr;
            hsize  = HSIZE_WORD;
            hwrite = 1'b0;
        end
        if ((sel_d || sel_i) && !err1) begin
            htrans = HTRANS_NSEQ;
        end
    end

    // Grants and completion responses; the owner register steers done/err.
    always_comb begin
        i_gnt  = sel_i && hready && !err1;
        d_gnt  = sel_d && hready && !err1;
        cmpl   = !rst && hready && (owner_q != OWN_NONE);
        i_done = cmpl && (owner_q == OWN_I) && !hresp;
        i_err  = cmpl && (owner_q == OWN_I) &&  hresp;
        d_done = cmpl && (owner_q == OWN_D) && !hresp;
        d_err  = cmpl && (owner_q == OWN_D) &&  hresp;
    end

    // Next data-phase owner and D-streak count.
    always_comb begin
        owner_d  = owner_q;
        streak_d = streak_q;
        // The address phase accepted on this edge becomes the next data
        // phase; with hready low everything holds.
        if (hready) begin
            if (i_gnt) begin
                owner_d = OWN_I;
            end else if (d_gnt) begin
                owner_d = OWN_D;
            end else begin
                owner_d = OWN_NONE;
            end
        end
        // The streak only counts D grants that made a waiting fetch wait
        // longer.
        if (!i_req || i_gnt) begin
            streak_d = '0;
        end else if (d_gnt && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + W_STREAK'(1);
        end
    end

    // State registers. Reset abandons any in-flight data phase silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q  <= OWN_NONE;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            streak_q <= '0;
        end else begin
            owner_q  <= owner_d;
            streak_q <= streak_d;
            if (d_gnt) begin
                wr_q    <= d_write;
                wdata_q <= d_wdata;
            end
        end
    end

    // Write data is only presented while a D store owns the data phase.
    assign hwdata     = ((owner_q == OWN_D) && wr_q) ? wdata_q : '0;
    assign rdata      = hrdata;
    assign dbg_owner  = owner_q;
    assign dbg_streak = streak_q;

endmodule

// File: tb/tb_revive_ahbl_arbiter.sv
// Bench for revive_ahbl_arbiter with MAX_D_STREAK = 2.
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled
// on the falling edge.
module tb_revive_ahbl_arbiter;

    localparam int W_ADDR = 32;
    localparam int W_DATA = 32;
    localparam int MAXS   = 2;
    localparam int W_STR  = $clog2(MAXS + 1);

    logic              clk;
    logic              rst;
    logic              i_req;
    logic [W_ADDR-1:0] i_addr;
    logic              i_gnt, i_done, i_err;
    logic              d_req;
    logic [W_ADDR-1:0] d_addr;
    logic [2:0]        d_size;
    logic              d_write;
    logic [W_DATA-1:0] d_wdata;
    logic              d_gnt, d_done, d_err;
    logic [W_DATA-1:0] rdata;
    logic              hready, hresp;
    logic [W_ADDR-1:0] haddr;
    logic              hwrite;
    logic [1:0]        htrans;
    logic [2:0]        hsize;
    logic [W_DATA-1:0] hwdata;
    logic [W_DATA-1:0] hrdata;
    logic [1:0]        dbg_owner;
    logic [W_STR-1:0]  dbg_streak;

    logic [5:0] flags;
    assign flags = {i_gnt, d_gnt, i_done, d_done, i_err, d_err};

    revive_ahbl_arbiter #(
        .W_ADDR(W_ADDR), .W_DATA(W_DATA), .MAX_D_STREAK(MAXS)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_done(i_done), .i_err(i_err),
        .d_req(d_req), .d_addr(d_addr), .d_size(d_size), .d_write(d_write),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_done(d_done), .d_err(d_err),
        .rdata(rdata),
        .hready(hready), .hresp(hresp), .haddr(haddr), .hwrite(hwrite),
        .htrans(htrans), .hsize(hsize), .hwdata(hwdata), .hrdata(hrdata),
        .dbg_owner(dbg_owner), .dbg_streak(dbg_streak)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [W_DATA-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic check_rdata(input string name);
        logic [W_DATA-1:0] e;
        if (exp_q.size() == 0) begin
            check({name, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(name, rdata, e);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input logic ir, input logic dr, input logic rdy, input logic rsp);
        i_req  = ir;
        d_req  = dr;
        hready = rdy;
        hresp  = rsp;
    endtask

    task automatic idle_inputs();
        set_bus(1'b0, 1'b0, 1'b1, 1'b0);
        i_addr  = 32'h0000_0040;
        d_addr  = 32'h0000_0200;
        d_size  = 3'd2;
        d_write = 1'b0;
        d_wdata = '0;
        hrdata  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        i_req;
        logic        d_req;
        logic        hready;
        logic        hresp;
        logic [5:0]  exp_flags;   // {i_gnt,d_gnt,i_done,d_done,i_err,d_err}
        logic [1:0]  exp_htrans;
        logic [31:0] exp_haddr;
    } vec_t;

    function automatic vec_t mk(input logic ir, input logic dr, input logic rdy, input logic rsp,
                                input logic [5:0] f, input logic [1:0] t, input logic [31:0] a);
        vec_t v;
        v.i_req = ir; v.d_req = dr; v.hready = rdy; v.hresp = rsp;
        v.exp_flags = f; v.exp_htrans = t; v.exp_haddr = a;
        return v;
    endfunction

    vec_t vecs[13];

    initial begin
        // Arbitration run with both requesters busy, then bus stalls and an
        // ERROR response. i_addr = 0x40, d_addr = 0x200, streak limit 2.
        vecs[0]  = mk(1, 1, 1, 0, 6'b010000, 2'b10, 32'h200); // D (streak 0)
        vecs[1]  = mk(1, 1, 1, 0, 6'b010100, 2'b10, 32'h200); // D (streak 1)
        vecs[2]  = mk(1, 1, 1, 0, 6'b100100, 2'b10, 32'h040); // I forced
        vecs[3]  = mk(1, 1, 1, 0, 6'b011000, 2'b10, 32'h200); // D, I done
        vecs[4]  = mk(1, 1, 1, 0, 6'b010100, 2'b10, 32'h200); // D
        vecs[5]  = mk(1, 1, 1, 0, 6'b100100, 2'b10, 32'h040); // I forced again
        vecs[6]  = mk(0, 0, 1, 0, 6'b001000, 2'b00, 32'h000); // idle, I done
        vecs[7]  = mk(0, 1, 0, 0, 6'b000000, 2'b10, 32'h200); // wait state: no grant
        vecs[8]  = mk(0, 1, 1, 0, 6'b010000, 2'b10, 32'h200); // D accepted
        vecs[9]  = mk(1, 0, 0, 1, 6'b000000, 2'b00, 32'h040); // ERROR cycle 1
        vecs[10] = mk(1, 0, 1, 1, 6'b100001, 2'b10, 32'h040); // ERROR cycle 2, I granted
        vecs[11] = mk(0, 0, 1, 0, 6'b001000, 2'b00, 32'h000); // I done
        vecs[12] = mk(0, 0, 1, 0, 6'b000000, 2'b00, 32'h000); // quiet

        // ===== reset state =====
        do_reset();
        @(negedge clk);
        check("reset_flags",  {26'd0, flags}, 32'd0);
        check("reset_htrans", {30'd0, htrans}, 32'd0);
        check("reset_hwdata", hwdata, 32'd0);
        check("reset_owner",  {30'd0, dbg_owner}, 32'd0);
        tick();

        // ===== table-driven vectors =====
        for (int i = 0; i < 13; i++) begin
            set_bus(vecs[i].i_req, vecs[i].d_req, vecs[i].hready, vecs[i].hresp);
            @(negedge clk);
            check($sformatf("vec%0d_flags", i),  {26'd0, flags}, {26'd0, vecs[i].exp_flags});
            check($sformatf("vec%0d_htrans", i), {30'd0, htrans}, {30'd0, vecs[i].exp_htrans});
            check($sformatf("vec%0d_haddr", i),  haddr, vecs[i].exp_haddr);
            tick();
        end

        // ===== async reset mid-cycle with a store in flight =====
        do_reset();
        d_req = 1'b1; d_write = 1'b1; d_wdata = 32'hAAAA_5555;
        @(negedge clk);
        check("rst_setup_dgnt", {31'd0, d_gnt}, 32'd1);
        tick();
        set_bus(1'b1, 1'b1, 1'b1, 1'b0);
        #2;
        check("rst_pre_hwdata", hwdata, 32'hAAAA_5555);
        rst = 1'b1;
        #1;
        check("rst_mid_flags",  {26'd0, flags}, 32'd0);
        check("rst_mid_htrans", {30'd0, htrans}, 32'd0);
        check("rst_mid_hwdata", hwdata, 32'd0);
        check("rst_mid_haddr",  haddr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        #1;
        check("rst_rel_flags", {26'd0, flags}, 32'd0);
        tick();
        @(negedge clk);
        check("rst_rel_flags2", {26'd0, flags}, 32'd0);
        tick();

        // ===== store with wait states =====
        do_reset();
        d_req = 1'b1; d_write = 1'b1; d_addr = 32'h100; d_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("st_gnt",    {26'd0, flags}, {26'd0, 6'b010000});
        check("st_haddr",  haddr, 32'h100);
        check("st_hwrite", {31'd0, hwrite}, 32'd1);
        tick();
        set_bus(1'b1, 1'b0, 1'b0, 1'b0);
        d_write = 1'b0; d_wdata = 32'h0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("st_wait%0d_hwdata", k), hwdata, 32'hCAFE_F00D);
            check($sformatf("st_wait%0d_flags", k), {26'd0, flags}, 32'd0);
            tick();
        end
        hready = 1'b1;
        @(negedge clk);
        check("st_done_hwdata", hwdata, 32'hCAFE_F00D);
        check("st_done_flags",  {26'd0, flags}, {26'd0, 6'b100100});
        tick();
        i_req = 1'b0;
        @(negedge clk);
        check("st_after_flags",  {26'd0, flags}, {26'd0, 6'b001000});
        check("st_after_hwdata", hwdata, 32'd0);
        tick();

        // ===== back-to-back I read then D load =====
        do_reset();
        i_req = 1'b1; i_addr = 32'h0;
        @(negedge clk);
        check("b2b_i_gnt", {26'd0, flags}, {26'd0, 6'b100000});
        exp_q.push_back(32'h1234_5678);
        tick();
        set_bus(1'b0, 1'b1, 1'b1, 1'b0);
        d_addr = 32'h200; d_write = 1'b0; hrdata = 32'h1234_5678;
        @(negedge clk);
        check("b2b_haddr",  haddr, 32'h200);
        check("b2b_htrans", {30'd0, htrans}, 32'h2);
        check("b2b_flags1", {26'd0, flags}, {26'd0, 6'b011000});
        if (i_done) check_rdata("b2b_i_rdata");
        exp_q.push_back(32'h0BAD_BEEF);
        tick();
        d_req = 1'b0; hrdata = 32'h0BAD_BEEF;
        @(negedge clk);
        check("b2b_flags2", {26'd0, flags}, {26'd0, 6'b000100});
        if (d_done) check_rdata("b2b_d_rdata");
        check("b2b_queue_drained", exp_q.size(), 32'd0);
        tick();

        // ===== two-cycle ERROR on a fetch with D waiting =====
        do_reset();
        i_req = 1'b1; i_addr = 32'h80;
        @(negedge clk);
        check("err_i_gnt", {26'd0, flags}, {26'd0, 6'b100000});
        tick();
        set_bus(1'b0, 1'b1, 1'b0, 1'b1);
        d_addr = 32'h300;
        @(negedge clk);
        check("err_c1_htrans", {30'd0, htrans}, 32'd0);
        check("err_c1_flags",  {26'd0, flags}, 32'd0);
        tick();
        hready = 1'b1;
        @(negedge clk);
        check("err_c2_flags", {26'd0, flags}, {26'd0, 6'b010010});
        tick();
        set_bus(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("err_c3_flags", {26'd0, flags}, {26'd0, 6'b000100});
        tick();

        // ===== fetch-only stream: I forces word size and read =====
        do_reset();
        set_bus(1'b1, 1'b0, 1'b1, 1'b0);
        d_write = 1'b1; d_size = 3'd0;
        for (int k = 0; k < 10; k++) begin
            i_addr = 32'h1000 + 32'(k * 4);
            @(negedge clk);
            check($sformatf("ionly%0d_flags", k), {26'd0, flags},
                  (k == 0) ? {26'd0, 6'b100000} : {26'd0, 6'b101000});
            check($sformatf("ionly%0d_haddr", k), haddr, 32'h1000 + 32'(k * 4));
            check($sformatf("ionly%0d_size_wr", k), {28'd0, hsize, hwrite}, {28'd0, 3'd2, 1'b0});
            check($sformatf("ionly%0d_streak", k), {30'd0, dbg_streak}, 32'd0);
            tick();
        end

        // ===== report =====
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
